spi_write_ctrl: RTL

SPI_WRITE_CTRL -- requirements
Module: spi_write_ctrl

---
 rtl/spi_write_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_write_ctrl.sv
// spi_write_ctrl: two-requester arbitrated 16-bit SPI write master with registered outputs
module spi_write_ctrl #(
  parameter int HALF_DIV = 2,
  parameter int CS_GAP   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic [7:0] ADDR0,
  input  logic [7:0] DATA0,
  output logic       GNT0,
  input  logic       REQ1,
  input  logic [7:0] ADDR1,
  input  logic [7:0] DATA1,
  output logic       GNT1,
  output logic       CS,
  output logic       SCLK,
  output logic       SDATA,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;
  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic        last_q, last_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        win;
  logic        half_end;
  assign win      = (REQ0 & REQ1) ? ~last_q : REQ1;
  assign half_end = cnt_q == HALF_LAST;
  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign CS    = cs_q;
  assign SCLK  = sclk_q;
  assign SDATA = sdata_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  // next-state and next-output computation; every output is a flop so it changes on the state-entering edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (REQ0 | REQ1) begin
          state_d = SETUP;
          word_d  = win ? {ADDR1, DATA1} : {ADDR0, DATA0};
          sdata_d = win ? ADDR1[7] : ADDR0[7];
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          idx_d   = 4'd15;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_d = SCK_HI;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end
      end
      SCK_HI: begin
        if (half_end) begin
          cnt_d  = 8'd0;
          sclk_d = 1'b0;
          if (idx_q != 4'd0) begin
            state_d = SCK_LO;
            idx_d   = idx_q - 4'd1;
            sdata_d = word_q[idx_q - 4'd1];
          end else begin
            state_d = HOLD;
          end
        end
      end
      SCK_LO: begin
        if (half_end) begin
          state_d = SCK_HI;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d = GAP;
          cnt_d   = 8'd0;
          cs_d    = 1'b1;
          sdata_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any frame and restores requester 0 priority
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      word_q  <= 16'd0;
      last_q  <= 1'b1;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
